i2c_slave_regs: RTL and testbench
=================================

# i2c_slave_regs

Parametrised I2C slave with an internal byte-wide register bank, the next generation of the team's single-byte test-bench slave. It decodes a configurable 7-bit address and supports multi-byte writes and reads with an auto-incrementing offset pointer, repeated START (random read) and master NACK. It also provides a local host port so on-chip logic can read and write the same registers. It sits between the open-drain SCL/SDA pads and core logic, clocked entirely by the system clock.

## Interface
- SLAVE_ADDR, 7'h23, 7-bit I2C address matched after START.
- REG_COUNT, 16, number of 8-bit registers; power of two, 2..256.
- FILTER_LEN, 3, consecutive identical samples required before the filtered SCL/SDA level changes.
- AW (localparam), clog2(REG_COUNT), offset/pointer width.

Ports:
- iClk  in  1  system clock.
- iRst  in  1  synchronous, active-high reset.
- iSCL  in  1  SCL pad input (asynchronous).
- iSDA  in  1  SDA pad input (asynchronous).
- oSDA  out  1  open-drain control: 0 = pull SDA low, 1 = release.
- iLocWe  in  1  local write strobe.
- iLocAddr  in  AW  local register address.
- iLocData  in  8  local write data.
- oLocData  out  8  registered read data for iLocAddr, 1-cycle latency.
- oWrStb  out  1  1-cycle pulse: I2C master wrote a register.
- oWrAddr  out  AW  register index written, valid with oWrStb.
- oWrData  out  8  byte written, valid with oWrStb.
- oRdStb  out  1  1-cycle pulse: a register was loaded for transmit.
- oBusy  out  1  high from an address match until STOP, or START not addressed to this slave.

## Operation
- Input path: 2-FF synchronizer on each pin, then a glitch filter; the filtered level changes only after FILTER_LEN equal samples. All edge and condition detection uses the filtered levels.
- START: filtered SDA falls while SCL is high. STOP: SDA rises while SCL is high. Both are recognised in every state.
- START or repeated START in any state goes to ADDR. STOP in any state goes to IDLE and releases oSDA.
- States:
  - IDLE: waits for START.
  - ADDR: shifts 8 bits MSB-first, sampled on SCL rising edge. On a match with SLAVE_ADDR, goes to ADDR_ACK; otherwise to IDLE, with no ACK.
  - ADDR_ACK: drives ACK. Then R/W=0 goes to OFFS; R/W=1 loads reg[ptr], pulses oRdStb and goes to RDATA.
  - OFFS: receives the offset byte. ptr = byte mod REG_COUNT. Goes to OFFS_ACK.
  - OFFS_ACK: ACKs, then goes to WDATA.
  - WDATA: receives a byte. reg[ptr] = byte, oWrStb pulses, ptr increments. Goes to WDATA_ACK.
  - WDATA_ACK: ACKs, then returns to WDATA.
  - RDATA: drives 8 bits MSB-first. Goes to RMACK.
  - RMACK: samples the master's ACK. ACK (SDA=0): ptr increments, reg[ptr] is loaded, oRdStb pulses, and the block returns to RDATA. NACK: the block releases SDA and waits for STOP or repeated START.
- Pointer wraps REG_COUNT-1 → 0 on both read and write.
- ptr persists across transactions, so write(offset) + Sr + read is a random read.
- Simultaneous I2C write and iLocWe to the same register in the same cycle: the I2C write wins. A local write to a different register proceeds.
- A transmit byte is latched at load time; later local writes do not alter a byte already in transmission.

## Timing
- Requirement: iClk ≥ 20× SCL frequency.
- Pin-to-filtered latency: 2 + FILTER_LEN cycles.
- oSDA updates within 1 cycle of the filtered SCL falling edge, for both ACK and data bits.
- oSDA is released on the SCL falling edge that ends the ACK or the bit.
- oWrStb is asserted 1 cycle after the SCL rising edge of bit 0 of a data byte.
- oRdStb is asserted in the cycle the shift register loads.
- Reset values:
  - oSDA=1, oLocData=0, oWrStb=0, oWrAddr=0, oWrData=0, oRdStb=0, oBusy=0.
  - All registers 0, ptr=0, state IDLE, filters initialised to 1.
- Reset asserted mid-transaction releases SDA in the next cycle. The bus is then ignored until the next START.

## Test plan
- Write 0x46, offset 0x02, data 0x11, 0x22, STOP → ACK on all 4 bytes. reg[2]=0x11, reg[3]=0x22. Two oWrStb pulses with oWrAddr 2 then 3.
- Write 0x46, offset 0x0F, data 0xAA, 0xBB → reg[15]=0xAA and reg[0]=0xBB (wrap).
- Random read: write 0x46, offset 0x02, Sr, 0x47, read 2 bytes (ACK, then NACK), STOP → SDA carries 0x11, 0x22. oSDA is released after the NACK.
- Address 0x48 (slave 0x24) → no ACK, oSDA stays 1, oBusy stays 0, and no registers change.
- Glitch of FILTER_LEN-1 cycles on SCL during a data bit → no extra bit is shifted and the received byte is correct. Local write iLocAddr=3, iLocData=0x5A, followed by a local read → oLocData=0x5A after 1 cycle.
- iRst pulsed while a read is driving a 0 bit → oSDA=1 on the next cycle. A subsequent full write transaction completes normally.

Source files
------------

// File: rtl/i2c_slave_regs.sv
// i2c_slave_regs: I2C slave with a byte-wide register bank, an auto-incrementing
// offset pointer shared by reads and writes, and a local host port that reads
// and writes the same registers. Everything runs on the system clock; SCL/SDA
// are oversampled, synchronised and glitch-filtered before any decoding.
module i2c_slave_regs #(
    parameter logic [6:0] SLAVE_ADDR = 7'h23,
    parameter int         REG_COUNT  = 16,
    parameter int         FILTER_LEN = 3,
    localparam int        AW         = $clog2(REG_COUNT)
) (
    input  logic          iClk,
    input  logic          iRst,
    input  logic          iSCL,
    input  logic          iSDA,
    output logic          oSDA,
    input  logic          iLocWe,
    input  logic [AW-1:0] iLocAddr,
    input  logic [7:0]    iLocData,
    output logic [7:0]    oLocData,
    output logic          oWrStb,
    output logic [AW-1:0] oWrAddr,
    output logic [7:0]    oWrData,
    output logic          oRdStb,
    output logic          oBusy
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_LEN - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_OFFS,
        S_OFFS_ACK,
        S_WDATA,
        S_WDATA_ACK,
        S_RDATA,
        S_RMACK
    } state_t;

    // Pin synchronisers and glitch filters
    logic          sclMeta_q, sclSync_q, sdaMeta_q, sdaSync_q;
    logic          sclFilt_q, sclFilt_d, sdaFilt_q, sdaFilt_d;
    logic [CW-1:0] sclCnt_q, sclCnt_d, sdaCnt_q, sdaCnt_d;
    logic          sclPrev_q, sdaPrev_q;

    // Bus conditions derived from the filtered levels
    logic          sclRise, sclFall, startDet, stopDet;

    // Protocol state
    state_t        state_q, state_d;
    logic [3:0]    bitCnt_q, bitCnt_d;
    logic [7:0]    rxShift_q, rxShift_d;
    logic [7:0]    txShift_q, txShift_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          rw_q, rw_d;
    logic          ackPhase_q, ackPhase_d;
    logic          mack_q, mack_d;
    logic          sdaOut_q, sdaOut_d;
    logic          busy_q, busy_d;
    logic          rdStb_q, rdStb_d;

    // Register bank and side-band outputs
    logic [7:0]    regs_q [REG_COUNT];
    logic [7:0]    locData_q;
    logic          wrStb_q;
    logic [AW-1:0] wrAddr_q;
    logic [7:0]    wrData_q;

    logic          i2cWe;
    logic [7:0]    rxByte;
    logic [AW-1:0] ptrInc;
    logic [7:0]    curByte, nextByte;

    assign rxByte   = {rxShift_q[6:0], sdaFilt_q};
    assign ptrInc   = ptr_q + AW'(1);
    assign curByte  = regs_q[ptr_q];
    assign nextByte = regs_q[ptrInc];

    assign sclRise  = sclFilt_q & ~sclPrev_q;
    assign sclFall  = ~sclFilt_q & sclPrev_q;
    assign startDet = sclFilt_q & sclPrev_q & sdaPrev_q & ~sdaFilt_q;
    assign stopDet  = sclFilt_q & sclPrev_q & ~sdaPrev_q & sdaFilt_q;

    assign oSDA     = sdaOut_q;
    assign oLocData = locData_q;
    assign oWrStb   = wrStb_q;
    assign oWrAddr  = wrAddr_q;
    assign oWrData  = wrData_q;
    assign oRdStb   = rdStb_q;
    assign oBusy    = busy_q;

    // Two-flop synchronisers; idle bus level is high
    always_ff @(posedge iClk) begin
        if (iRst) begin
            sclMeta_q <= 1'b1;
            sclSync_q <= 1'b1;
            sdaMeta_q <= 1'b1;
            sdaSync_q <= 1'b1;
        end else begin
            sclMeta_q <= iSCL;
            sclSync_q <= sclMeta_q;
            sdaMeta_q <= iSDA;
            sdaSync_q <= sdaMeta_q;
        end
    end

    // Filter: the filtered level follows the pin only after FILTER_LEN agreeing samples
    always_comb begin
        sclFilt_d = sclFilt_q;
        sclCnt_d  = '0;
        sdaFilt_d = sdaFilt_q;
        sdaCnt_d  = '0;
        if (sclSync_q != sclFilt_q) begin
            if (sclCnt_q == CNT_MAX) sclFilt_d = sclSync_q;
            else                     sclCnt_d  = sclCnt_q + CW'(1);
        end
        if (sdaSync_q != sdaFilt_q) begin
            if (sdaCnt_q == CNT_MAX) sdaFilt_d = sdaSync_q;
            else                     sdaCnt_d  = sdaCnt_q + CW'(1);
        end
    end

    // Filter state plus one-cycle-delayed copies for edge detection
    always_ff @(posedge iClk) begin
        if (iRst) begin
            sclFilt_q <= 1'b1;
            sdaFilt_q <= 1'b1;
            sclCnt_q  <= '0;
            sdaCnt_q  <= '0;
            sclPrev_q <= 1'b1;
            sdaPrev_q <= 1'b1;
        end else begin
            sclFilt_q <= sclFilt_d;
            sdaFilt_q <= sdaFilt_d;
            sclCnt_q  <= sclCnt_d;
            sdaCnt_q  <= sdaCnt_d;
            sclPrev_q <= sclFilt_q;
            sdaPrev_q <= sdaFilt_q;
        end
    end

    // Protocol FSM: STOP and START override every state; otherwise bits are
    // taken on SCL rise and SDA is only changed on SCL fall
    always_comb begin
        state_d    = state_q;
        bitCnt_d   = bitCnt_q;
        rxShift_d  = rxShift_q;
        txShift_d  = txShift_q;
        ptr_d      = ptr_q;
        rw_d       = rw_q;
        ackPhase_d = ackPhase_q;
        mack_d     = mack_q;
        sdaOut_d   = sdaOut_q;
        busy_d     = busy_q;
        rdStb_d    = 1'b0;
        i2cWe      = 1'b0;

        if (stopDet) begin
            state_d  = S_IDLE;
            sdaOut_d = 1'b1;
            busy_d   = 1'b0;
        end else if (startDet) begin
            state_d  = S_ADDR;
            bitCnt_d = '0;
            sdaOut_d = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    sdaOut_d = 1'b1;
                end
                S_ADDR: begin
                    if (sclRise) begin
                        rxShift_d = rxByte;
                        bitCnt_d  = bitCnt_q + 4'd1;
                        if (bitCnt_q == 4'd7) begin
                            bitCnt_d   = '0;
                            ackPhase_d = 1'b0;
                            if (rxByte[7:1] == SLAVE_ADDR) begin
                                state_d = S_ADDR_ACK;
                                rw_d    = rxByte[0];
                                busy_d  = 1'b1;
                            end else begin
                                state_d = S_IDLE;
                                busy_d  = 1'b0;
                            end
                        end
                    end
                end
                S_OFFS, S_WDATA: begin
                    if (sclRise) begin
                        rxShift_d = rxByte;
                        bitCnt_d  = bitCnt_q + 4'd1;
                        if (bitCnt_q == 4'd7) begin
                            bitCnt_d   = '0;
                            ackPhase_d = 1'b0;
                            if (state_q == S_OFFS) begin
                                ptr_d   = rxByte[AW-1:0];
                                state_d = S_OFFS_ACK;
                            end else begin
                                i2cWe   = 1'b1;
                                ptr_d   = ptrInc;
                                state_d = S_WDATA_ACK;
                            end
                        end
                    end
                end
                S_ADDR_ACK, S_OFFS_ACK, S_WDATA_ACK: begin
                    if (sclFall) begin
                        if (!ackPhase_q) begin
                            ackPhase_d = 1'b1;
                            sdaOut_d   = 1'b0;
                        end else begin
                            ackPhase_d = 1'b0;
                            bitCnt_d   = '0;
                            sdaOut_d   = 1'b1;
                            if (state_q == S_ADDR_ACK && rw_q) begin
                                txShift_d = curByte;
                                rdStb_d   = 1'b1;
                                sdaOut_d  = curByte[7];
                                state_d   = S_RDATA;
                            end else if (state_q == S_ADDR_ACK) begin
                                state_d = S_OFFS;
                            end else begin
                                state_d = S_WDATA;
                            end
                        end
                    end
                end
                S_RDATA: begin
                    if (sclRise) begin
                        bitCnt_d = bitCnt_q + 4'd1;
                    end else if (sclFall) begin
                        if (bitCnt_q == 4'd8) begin
                            bitCnt_d = '0;
                            sdaOut_d = 1'b1;
                            mack_d   = 1'b0;
                            state_d  = S_RMACK;
                        end else begin
                            sdaOut_d = txShift_q[~bitCnt_q[2:0]];
                        end
                    end
                end
                S_RMACK: begin
                    if (sclRise) begin
                        mack_d = ~sdaFilt_q;
                    end else if (sclFall) begin
                        if (mack_q) begin
                            ptr_d     = ptrInc;
                            txShift_d = nextByte;
                            rdStb_d   = 1'b1;
                            sdaOut_d  = nextByte[7];
                            bitCnt_d  = '0;
                            state_d   = S_RDATA;
                        end else begin
                            sdaOut_d = 1'b1;
                            state_d  = S_IDLE;
                        end
                    end
                end
                default: begin
                    state_d  = S_IDLE;
                    sdaOut_d = 1'b1;
                end
            endcase
        end
    end

    // FSM and datapath registers
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q    <= S_IDLE;
            bitCnt_q   <= '0;
            rxShift_q  <= '0;
            txShift_q  <= '0;
            ptr_q      <= '0;
            rw_q       <= 1'b0;
            ackPhase_q <= 1'b0;
            mack_q     <= 1'b0;
            sdaOut_q   <= 1'b1;
            busy_q     <= 1'b0;
            rdStb_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            bitCnt_q   <= bitCnt_d;
            rxShift_q  <= rxShift_d;
            txShift_q  <= txShift_d;
            ptr_q      <= ptr_d;
            rw_q       <= rw_d;
            ackPhase_q <= ackPhase_d;
            mack_q     <= mack_d;
            sdaOut_q   <= sdaOut_d;
            busy_q     <= busy_d;
            rdStb_q    <= rdStb_d;
        end
    end

    // Register bank: the I2C write is issued last so it wins a same-address collision
    always_ff @(posedge iClk) begin
        if (iRst) begin
            for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
        end else begin
            if (iLocWe) regs_q[iLocAddr] <= iLocData;
            if (i2cWe)  regs_q[ptr_q]    <= rxByte;
        end
    end

    // Registered local read port and I2C write notification
    always_ff @(posedge iClk) begin
        if (iRst) begin
            locData_q <= '0;
            wrStb_q   <= 1'b0;
            wrAddr_q  <= '0;
            wrData_q  <= '0;
        end else begin
            locData_q <= regs_q[iLocAddr];
            wrStb_q   <= i2cWe;
            if (i2cWe) begin
                wrAddr_q <= ptr_q;
                wrData_q <= rxByte;
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Testbench for i2c_slave_regs: a bit-banged I2C master drives the bus, a
// behavioural register model predicts writes and read bytes, and monitors
// compare the DUT's strobes and transmitted bytes against queued expectations.
module tb_i2c_slave_regs;

    localparam int Q         = 10;
    localparam int REG_COUNT = 16;
    localparam int AW        = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          mScl, mSda;
    logic          sdaBus;
    logic          oSDA;
    logic          iLocWe;
    logic [AW-1:0] iLocAddr;
    logic [7:0]    iLocData;
    logic [7:0]    oLocData;
    logic          oWrStb;
    logic [AW-1:0] oWrAddr;
    logic [7:0]    oWrData;
    logic          oRdStb;
    logic          oBusy;

    int            vecCount  = 0;
    int            missCount = 0;
    int            sdaLowCount = 0;

    logic [7:0]    model [REG_COUNT];
    int            mPtr;
    logic [11:0]   expWrQ [$];
    logic [7:0]    expRdQ [$];
    logic [11:0]   wrExp;

    i2c_slave_regs #(
        .SLAVE_ADDR(7'h23),
        .REG_COUNT (REG_COUNT),
        .FILTER_LEN(3)
    ) dut (
        .iClk    (clock),
        .iRst    (reset),
        .iSCL    (mScl),
        .iSDA    (sdaBus),
        .oSDA    (oSDA),
        .iLocWe  (iLocWe),
        .iLocAddr(iLocAddr),
        .iLocData(iLocData),
        .oLocData(oLocData),
        .oWrStb  (oWrStb),
        .oWrAddr (oWrAddr),
        .oWrData (oWrData),
        .oRdStb  (oRdStb),
        .oBusy   (oBusy)
    );

    assign sdaBus = mSda & oSDA;

    // 10 ns system clock
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        vecCount++;
        if (act !== req) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Counts cycles in which the slave pulls SDA low
    always @(negedge clock) begin
        if (oSDA == 1'b0) sdaLowCount++;
    end

    // Write monitor: every oWrStb must match the oldest predicted register write
    always @(negedge clock) begin
        if (!reset && oWrStb) begin
            if (expWrQ.size() == 0) begin
                checkOutput("unexpectedWrStb", 32'd1, 32'd0);
            end else begin
                wrExp = expWrQ.pop_front();
                checkOutput("wrAddr", 32'(oWrAddr), 32'(wrExp[11:8]));
                checkOutput("wrData", 32'(oWrData), 32'(wrExp[7:0]));
            end
        end
    end

    // Read monitor: after each oRdStb collect the 8 bits seen on the bus
    initial begin : rdMonitor
        logic [7:0] got, expByte;
        logic       prevScl, aborted;
        int         nb, budget;
        forever begin
            @(negedge clock);
            if (!reset && oRdStb) begin
                if (expRdQ.size() == 0) begin
                    checkOutput("unexpectedRdStb", 32'd1, 32'd0);
                end else begin
                    expByte = expRdQ.pop_front();
                    got = '0; nb = 0; budget = 0; aborted = 1'b0; prevScl = mScl;
                    while (nb < 8 && !aborted && budget < 1000) begin
                        @(negedge clock);
                        budget++;
                        if (reset) aborted = 1'b1;
                        else if (mScl && !prevScl) begin
                            got = {got[6:0], sdaBus};
                            nb++;
                        end
                        prevScl = mScl;
                    end
                    if (!aborted) begin
                        if (nb < 8) checkOutput("rdTimeout", 32'(nb), 32'd8);
                        else        checkOutput("rdByte", 32'(got), 32'(expByte));
                    end
                end
            end
        end
    end

    // Master bus primitives
    task automatic sendBit(input logic b, input logic glitch, output logic s);
        if (glitch) begin
            waitCycles(3);
            mScl = 1'b1;
            waitCycles(2);
            mScl = 1'b0;
            waitCycles(Q - 5);
        end else begin
            waitCycles(Q);
        end
        mSda = b;
        waitCycles(Q);
        mScl = 1'b1;
        waitCycles(Q);
        s = sdaBus;
        waitCycles(Q);
        mScl = 1'b0;
    endtask

    task automatic i2cStart();
        waitCycles(Q);
        mSda = 1'b1;
        waitCycles(Q);
        mScl = 1'b1;
        waitCycles(Q);
        mSda = 1'b0;
        waitCycles(Q);
        mScl = 1'b0;
    endtask

    task automatic i2cStop();
        waitCycles(Q);
        mSda = 1'b0;
        waitCycles(Q);
        mScl = 1'b1;
        waitCycles(Q);
        mSda = 1'b1;
        waitCycles(Q);
    endtask

    task automatic sendByte(input logic [7:0] b, input logic glitch, output logic acked);
        logic s;
        for (int i = 7; i >= 0; i--) sendBit(b[i], glitch && (i == 4), s);
        sendBit(1'b1, 1'b0, s);
        acked = ~s;
    endtask

    task automatic recvByte(input logic ack, output logic [7:0] b);
        logic s;
        b = '0;
        for (int i = 0; i < 8; i++) begin
            sendBit(1'b1, 1'b0, s);
            b = {b[6:0], s};
        end
        sendBit(~ack, 1'b0, s);
    endtask

    // Local host write; the model tracks it immediately
    task automatic applyStimulus(input int addr, input logic [7:0] data);
        iLocWe   = 1'b1;
        iLocAddr = AW'(addr);
        iLocData = data;
        waitCycles(1);
        iLocWe   = 1'b0;
        model[addr % REG_COUNT] = data;
    endtask

    task automatic localRead(input int addr, input string name);
        iLocAddr = AW'(addr);
        waitCycles(1);
        checkOutput(name, 32'(oLocData), 32'(model[addr % REG_COUNT]));
    endtask

    // Write transaction: address, offset, data bytes, optional STOP
    task automatic writeTxn(input int offs, input logic [7:0] data[$], input logic glitch, input logic doStop);
        logic a;
        i2cStart();
        sendByte({7'h23, 1'b0}, 1'b0, a);
        checkOutput("addrAck", 32'(a), 32'd1);
        checkOutput("busyAfterMatch", 32'(oBusy), 32'd1);
        sendByte(8'(offs), 1'b0, a);
        checkOutput("offsAck", 32'(a), 32'd1);
        mPtr = offs % REG_COUNT;
        foreach (data[i]) begin
            expWrQ.push_back({4'(mPtr), data[i]});
            model[mPtr] = data[i];
            mPtr = (mPtr + 1) % REG_COUNT;
            sendByte(data[i], glitch && (i == 0), a);
            checkOutput("dataAck", 32'(a), 32'd1);
        end
        if (doStop) begin
            i2cStop();
            checkOutput("busyAfterStop", 32'(oBusy), 32'd0);
        end
    endtask

    // Read transaction from the current pointer: ACK all but the last byte
    task automatic readTxn(input int n);
        logic       a;
        logic [7:0] b;
        for (int k = 0; k < n; k++) expRdQ.push_back(model[(mPtr + k) % REG_COUNT]);
        i2cStart();
        sendByte({7'h23, 1'b1}, 1'b0, a);
        checkOutput("rdAddrAck", 32'(a), 32'd1);
        for (int k = 0; k < n; k++) recvByte(k < n - 1, b);
        mPtr = (mPtr + n - 1) % REG_COUNT;
        checkOutput("sdaReleasedAfterNack", 32'(oSDA), 32'd1);
        i2cStop();
        checkOutput("busyAfterRead", 32'(oBusy), 32'd0);
    endtask

    // Watchdog: the run must finish on its own
    initial begin
        #1000000;
        missCount++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : mainSeq
        logic [7:0] dq [$];
        logic       a;
        int         lowBefore, offs, n;

        mScl = 1'b1; mSda = 1'b1;
        iLocWe = 1'b0; iLocAddr = '0; iLocData = '0;
        reset = 1'b1;
        for (int i = 0; i < REG_COUNT; i++) model[i] = 8'h00;
        mPtr = 0;
        waitCycles(5);
        checkOutput("rstSDA", 32'(oSDA), 32'd1);
        checkOutput("rstLocData", 32'(oLocData), 32'd0);
        checkOutput("rstWrStb", 32'(oWrStb), 32'd0);
        checkOutput("rstWrAddr", 32'(oWrAddr), 32'd0);
        checkOutput("rstWrData", 32'(oWrData), 32'd0);
        checkOutput("rstRdStb", 32'(oRdStb), 32'd0);
        checkOutput("rstBusy", 32'(oBusy), 32'd0);
        reset = 1'b0;
        waitCycles(20);

        $display("[TB] multi-byte write at offset 2");
        dq = {8'h11, 8'h22};
        writeTxn(2, dq, 1'b0, 1'b1);
        localRead(2, "reg2");
        localRead(3, "reg3");

        $display("[TB] pointer wrap on write");
        dq = {8'hAA, 8'hBB};
        writeTxn(15, dq, 1'b0, 1'b1);
        localRead(15, "reg15");
        localRead(0, "reg0Wrap");

        $display("[TB] random read via repeated start");
        dq = {};
        writeTxn(2, dq, 1'b0, 1'b0);
        readTxn(2);

        $display("[TB] foreign address");
        lowBefore = sdaLowCount;
        i2cStart();
        sendByte(8'h48, 1'b0, a);
        checkOutput("foreignNoAck", 32'(a), 32'd0);
        checkOutput("foreignBusy", 32'(oBusy), 32'd0);
        sendByte(8'($urandom), 1'b0, a);
        i2cStop();
        checkOutput("foreignSdaIdle", 32'(sdaLowCount - lowBefore), 32'd0);
        for (int i = 0; i < REG_COUNT; i++) localRead(i, "foreignRegs");

        $display("[TB] SCL glitch during data bit");
        dq = {8'($urandom)};
        writeTxn(7, dq, 1'b1, 1'b1);
        localRead(7, "glitchByte");

        $display("[TB] local write and read back");
        applyStimulus(3, 8'h5A);
        localRead(3, "localRW");

        $display("[TB] randomized transactions");
        for (int t = 0; t < 4; t++) begin
            offs = $urandom_range(0, 255);
            n    = $urandom_range(1, 3);
            dq   = {};
            for (int k = 0; k < n; k++) dq.push_back(8'($urandom));
            writeTxn(offs, dq, 1'b0, 1'b1);
            applyStimulus($urandom_range(0, REG_COUNT - 1), 8'($urandom));
            dq = {};
            writeTxn($urandom_range(0, 255), dq, 1'b0, 1'b0);
            readTxn($urandom_range(1, 3));
        end

        $display("[TB] reset during read");
        dq = {8'h3C};
        writeTxn(5, dq, 1'b0, 1'b1);
        dq = {};
        writeTxn(5, dq, 1'b0, 1'b0);
        expRdQ.push_back(model[mPtr]);
        i2cStart();
        sendByte({7'h23, 1'b1}, 1'b0, a);
        checkOutput("rdAddrAck", 32'(a), 32'd1);
        waitCycles(Q);
        checkOutput("rdBitLow", 32'(oSDA), 32'd0);
        reset = 1'b1;
        waitCycles(1);
        checkOutput("rstReleasesSda", 32'(oSDA), 32'd1);
        reset = 1'b0;
        for (int i = 0; i < REG_COUNT; i++) model[i] = 8'h00;
        mPtr = 0;
        checkOutput("rstBusyMid", 32'(oBusy), 32'd0);
        i2cStop();
        dq = {8'($urandom), 8'($urandom)};
        writeTxn(1, dq, 1'b0, 1'b1);
        localRead(5, "reg5Cleared");

        $display("[TB] final bank comparison");
        for (int i = 0; i < REG_COUNT; i++) localRead(i, "finalRegs");
        waitCycles(50);
        checkOutput("wrQueueDrained", 32'(expWrQ.size()), 32'd0);
        checkOutput("rdQueueDrained", 32'(expRdQ.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
